uvw_monitor: RTL and testbench

Observer for the u/v/w counter-triple benchmark. It consumes one producer snapshot per `in_valid` beat: the producer's reset input plus its registered `u`, `v`, `w` values. From each snapshot it predicts the producer's next values and compares them against the following snapshot. It also checks the safety property `(u + v) != 1` on every beat. The block sits downstream of the producer, either in simulation benches or as a standalone model-checking sample, and reports violations as registered pulses plus a sticky error.

---
 rtl/uvw_monitor.sv | 99 +++++++++
 tb/tb_uvw_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uvw_monitor.sv
// Observer for the u/v/w counter-triple producer: predicts each next snapshot, checks (u+v)!=1.
// Optional build macro UVW_MONITOR_ASSERT_EN adds an immediate assertion on the sticky error.
module uvw_monitor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_rst,
  input  logic [WIDTH-1:0] u_in,
  input  logic [WIDTH-1:0] v_in,
  input  logic [WIDTH-1:0] w_in,
  output logic             mismatch,
  output logic             prop_fail,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ERROR = 2'd2} state_t;

  state_t           state_p1, state_nxt;
  logic [WIDTH-1:0] pu_p1, pv_p1, pw_p1;
  logic [WIDTH-1:0] sum_uv;
  logic             accept, mism_c, pfail_c;

  // Next producer triple; all sums wrap modulo 2^WIDTH.
  function automatic logic [3*WIDTH-1:0] predict(input logic r, input logic [WIDTH-1:0] u,
                                                 input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] nu, nv, nw;
    if (r) begin
      nu = WIDTH'(1);
      nv = WIDTH'(1);
      nw = WIDTH'(1);
    end else begin
      nv = v + WIDTH'(1);
      nw = w + WIDTH'(1);
      nu = ((u < v) || (v < w)) ? (u + v) : nv;
    end
    return {nu, nv, nw};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : (c + CNT_W'(1));
  endfunction

  assign sum_uv  = u_in + v_in;
  assign accept  = in_valid && (state_p1 != ERROR);
  assign mism_c  = accept && (state_p1 == TRACK) && ({u_in, v_in, w_in} != {pu_p1, pv_p1, pw_p1});
  assign pfail_c = accept && (sum_uv == WIDTH'(1));

  always_comb begin
    state_nxt = state_p1;
    if (accept) begin
      state_nxt = (mism_c || pfail_c) ? ERROR : TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Registered outputs and shadow triple; a beat in cycle N is visible in cycle N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch   <= 1'b0;
      prop_fail  <= 1'b0;
      err        <= 1'b0;
      sample_cnt <= '0;
      pu_p1      <= '0;
      pv_p1      <= '0;
      pw_p1      <= '0;
    end else begin
      mismatch  <= mism_c;
      prop_fail <= pfail_c;
      err       <= err | mism_c | pfail_c;
      if (accept) begin
        sample_cnt             <= sat_inc(sample_cnt);
        {pu_p1, pv_p1, pw_p1}  <= predict(in_rst, u_in, v_in, w_in);
      end
    end
  end

  assign state = state_p1;

`ifdef UVW_MONITOR_ASSERT_EN
  always_comb begin
    mon_ok: assert (!err);
  end
`else
  // No assertion in the default build; outputs are unaffected either way.
`endif

endmodule

// File: tb/tb_uvw_monitor.sv
// Directed bench for uvw_monitor: two instances (CNT_W=8 and CNT_W=4) share one stimulus stream.
module tb_uvw_monitor;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_rst;
  logic [2:0] u_in, v_in, w_in;
  logic       mismatch, prop_fail, err;
  logic [1:0] state;
  logic [7:0] sample_cnt;
  logic       mismatch_b, prop_fail_b, err_b;
  logic [1:0] state_b;
  logic [3:0] sample_cnt_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  uvw_monitor #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rst(in_rst),
    .u_in(u_in), .v_in(v_in), .w_in(w_in),
    .mismatch(mismatch), .prop_fail(prop_fail), .err(err),
    .state(state), .sample_cnt(sample_cnt));

  uvw_monitor #(.WIDTH(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rst(in_rst),
    .u_in(u_in), .v_in(v_in), .w_in(w_in),
    .mismatch(mismatch_b), .prop_fail(prop_fail_b), .err(err_b),
    .state(state_b), .sample_cnt(sample_cnt_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle from a negedge; outputs are sampled at the following negedge.
  task automatic step(input logic vld, input logic r, input logic [2:0] u, input logic [2:0] v,
                      input logic [2:0] w);
    in_valid = vld;
    in_rst   = r;
    u_in     = u;
    v_in     = v;
    w_in     = w;
    @(negedge clk);
  endtask

  task automatic beat(input logic r, input logic [2:0] u, input logic [2:0] v, input logic [2:0] w);
    step(1'b1, r, u, v, w);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  // Beats whose prediction goes through the u+v branch (hand-computed chain, no errors).
  logic [2:0] br_u [7] = '{3'd1, 3'd3, 3'd6, 3'd2, 3'd7, 3'd5, 3'd4};
  logic [2:0] br_v [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] br_w [7] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rst = 1'b0; u_in = '0; v_in = '0; w_in = '0;
    @(negedge clk);
    idle();
    rst = 1'b0;
    chk("rst_mismatch", 32'(mismatch), 0);
    chk("rst_prop", 32'(prop_fail), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);

    // Correct wrapping stream (k,k,k); also saturates the 4-bit counter.
    beat(1'b1, 3'd0, 3'd0, 3'd0);
    for (int k = 1; k < 20; k++) begin
      beat(1'b0, 3'(k), 3'(k), 3'(k));
      chk("seq_pulses", {30'd0, mismatch, prop_fail}, 0);
      if (k == 9) begin
        chk("seq10_cnt", 32'(sample_cnt), 10);
        chk("seq10_state", 32'(state), 1);
        chk("seq10_err", 32'(err), 0);
      end
    end
    chk("seq20_cnt", 32'(sample_cnt), 20);
    chk("sat_cnt", 32'(sample_cnt_b), 15);
    chk("sat_err", 32'(err_b), 0);
    beat(1'b0, 3'd4, 3'd4, 3'd4);
    chk("sat_hold", 32'(sample_cnt_b), 15);
    chk("sat_state", 32'(state_b), 1);

    // Mismatch on third beat, then frozen in ERROR.
    do_reset();
    beat(1'b1, 3'd0, 3'd0, 3'd0);
    beat(1'b0, 3'd1, 3'd1, 3'd1);
    chk("mm_pre", 32'(mismatch), 0);
    beat(1'b0, 3'd3, 3'd2, 3'd2);
    chk("mm_pulse", 32'(mismatch), 1);
    chk("mm_prop", 32'(prop_fail), 0);
    chk("mm_err", 32'(err), 1);
    chk("mm_state", 32'(state), 2);
    chk("mm_cnt", 32'(sample_cnt), 3);
    idle();
    chk("mm_one_cycle", 32'(mismatch), 0);
    beat(1'b0, 3'd2, 3'd2, 3'd2);
    beat(1'b0, 3'd0, 3'd1, 3'd0);
    chk("err_frozen_cnt", 32'(sample_cnt), 3);
    chk("err_no_pulse", {30'd0, mismatch, prop_fail}, 0);
    chk("err_sticky", 32'(err), 1);

    // Reset with a concurrent beat while in ERROR: the beat is discarded.
    rst = 1'b1;
    beat(1'b1, 3'd0, 3'd0, 3'd0);
    rst = 1'b0;
    chk("rstbeat_err", 32'(err), 0);
    chk("rstbeat_state", 32'(state), 0);
    chk("rstbeat_cnt", 32'(sample_cnt), 0);
    beat(1'b0, 3'd1, 3'd1, 3'd1);
    chk("after_rst_state", 32'(state), 1);
    chk("after_rst_cnt", 32'(sample_cnt), 1);
    chk("after_rst_mm", 32'(mismatch), 0);

    // Property failure on first beat after reset.
    do_reset();
    beat(1'b0, 3'd0, 3'd1, 3'd5);
    chk("pf_pulse", 32'(prop_fail), 1);
    chk("pf_mm", 32'(mismatch), 0);
    chk("pf_err", 32'(err), 1);
    chk("pf_state", 32'(state), 2);
    chk("pf_cnt", 32'(sample_cnt), 1);
    idle();
    chk("pf_one_cycle", 32'(prop_fail), 0);
    chk("pf_sticky", 32'(err), 1);

    // u+v branch chain with 5-cycle gaps, then a beat failing both checks (4+5 wraps to 1).
    do_reset();
    for (int i = 0; i < 7; i++) begin
      beat(1'b0, br_u[i], br_v[i], br_w[i]);
      chk("gap_pulses", {30'd0, mismatch, prop_fail}, 0);
      for (int g = 0; g < 5; g++) idle();
    end
    chk("gap_cnt", 32'(sample_cnt), 7);
    chk("gap_state", 32'(state), 1);
    chk("gap_err", 32'(err), 0);
    beat(1'b0, 3'd4, 3'd5, 3'd2);
    chk("both_pulses", {30'd0, mismatch, prop_fail}, 3);
    chk("both_state", 32'(state), 2);
    chk("both_cnt", 32'(sample_cnt), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
